// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing: pixel/line counters, active-low syncs,
// visible-region flag, frame-start pulse and a wrapping frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;
  logic       line_end;
  logic       frame_end;

  // Every registered output is decoded from the next counter values, so all
  // outputs in one cycle describe the same (DrawX, DrawY).
  always_comb begin
    line_end  = (x_q == H_LAST);
    frame_end = line_end && (y_q == V_LAST);
    x_d       = line_end ? 10'd0 : x_q + 10'd1;
    y_d       = y_q;
    if (frame_end) begin
      y_d = 10'd0;
    end else if (line_end) begin
      y_d = y_q + 10'd1;
    end
    hs_d    = !((x_d >= HS_START) && (x_d < HS_END));
    vs_d    = !((y_d >= VS_START) && (y_d < VS_END));
    blank_d = (x_d < H_VIS) && (y_d < V_VIS);
    fs_d    = frame_end;
    fc_d    = frame_end ? fc_q + 8'd1 : fc_q;
  end

  // Reset values describe pixel (0,0) but without a frame_start pulse.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60Hz VGA raster timing for the whole display path, driven by the 25 MHz pixel clock.
- Sits directly upstream of the full-screen sprite renderers (lose, win and title screens). It drives their DrawX, DrawY and blank inputs, and drives the monitor hsync/vsync pins.
- Also provides a frame-start pulse and a free-running frame counter for sprite animation and screen-timeout logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- vga_clk  in  1  pixel clock, 25 MHz, the only clock
- reset  in  1  asynchronous, active-high reset
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current vertical position, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  1 = visible region (pixel may be driven), 0 = force black
- frame_start  out  1  one-cycle pulse at the first pixel of each frame
- frame_count  out  8  frames completed since reset, wraps mod 256

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_* parameters (800 by default); V_TOTAL = sum of the four V_* parameters (525 by default).
- All outputs are flop outputs, with no combinational path to the outputs. Logic derives next-state values from the next counter values, so every output in a given cycle describes the same (DrawX, DrawY).
- Reset: while reset=1 and immediately after it asserts, regardless of vga_clk:
  - DrawX=0, DrawY=0
  - hs=1, vs=1, blank=1
  - frame_start=0, frame_count=0
- Reset asserted mid-frame returns to these values immediately. Counting resumes on the first vga_clk rising edge after release.
- Horizontal counter: DrawX increments by 1 every cycle. At H_TOTAL-1 it wraps to 0 and DrawY increments.
- Vertical counter: at DrawY=V_TOTAL-1 with DrawX=H_TOTAL-1, both counters wrap to 0.
- hs: 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC. Default: DrawX 656..751.
- vs: 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, for the entire line. Default: lines 490..491.
- blank: 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- frame_start:
  - Asserts for exactly one cycle, the cycle in which (DrawX, DrawY)=(0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Does not assert for the initial (0,0) immediately after reset release.
- frame_count: increments by 1 in the same cycle that frame_start asserts; 255 wraps to 0.
- Period: exactly H_TOTAL*V_TOTAL cycles per frame (420000 by default). Consecutive frame_start pulses are exactly that many cycles apart.
- Downstream consumers register pixels on posedge and read ROMs on negedge. This block guarantees DrawX/DrawY are stable for the full cycle after each rising edge.

Test Plan:
- Reset values: assert reset mid-line at DrawX=300, DrawY=100 -> all outputs return immediately to the reset values (0, 0, hs=1, vs=1, blank=1, frame_start=0, frame_count=0) without a clock edge. After release, DrawX counts 0,1,2,... from the first edge.
- Horizontal timing on line 10: DrawX=639 -> blank=1; DrawX=640 -> blank=0. hs=1 at DrawX=655; hs=0 from 656 through 751; hs=1 at 752. DrawX=799 wraps to 0 with DrawY 10 -> 11.
- Vertical timing:
  - vs=1 throughout line 489, vs=0 for all of lines 490 and 491, vs=1 at line 492.
  - blank=0 for every pixel of line 480.
  - blank=1 at (0, 479).
- Frame wrap: from (799, 524) -> next cycle (0, 0) with frame_start=1 for exactly one cycle and frame_count 0 -> 1. No frame_start occurs on the first (0,0) after reset.
- Period check: over 3 frames, frame_start pulses are exactly 420000 cycles apart. Exactly 640*480 = 307200 blank=1 cycles per frame; hs low 96 cycles per line; vs low 1600 cycles per frame.
- Counter wrap: run 256 frames from reset -> frame_count reads 255 after the 255th pulse and 0 after the 256th.
